flip_candidate_sequencer: RTL and testbench

- Control stage directly upstream of the variable flip selector.
- Accepts the literal variable IDs of one chosen unsatisfied clause and fetches each variable's clause-broken and mask vectors from the clause-state lookup, one literal per request/ack handshake.
- Presents each fetched vector to the selector with the matching write-enable code, then issues the all-ones select code.
- Captures the selector's decision and emits the winning variable ID plus its clause-valid bits to the flip stage, using a valid/ready handshake.

---
 rtl/flip_candidate_sequencer_pkg.sv | 33 +++
 rtl/flip_candidate_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_flip_candidate_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flip_candidate_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// flip_candidate_sequencer_pkg
// Shared definitions for the flip candidate sequencer: the FSM state type,
// default sizing constants and the selector write-enable encoding.
// -----------------------------------------------------------------------------
package flip_candidate_sequencer_pkg;

  // Default sizing: MC is the width of the per-variable clause vectors and
  // NSAT_BITS the width of a literal-slot index / selector code.
  localparam int MC               = 20;
  localparam int DEFAULT_NSAT     = 3;
  localparam int DEFAULT_VAR_BITS = 16;
  localparam int NSAT_BITS        = $clog2(DEFAULT_NSAT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    APPLY,
    SETTLE,
    OUT
  } seq_state_e;

  // Write-enable code presented to the selector while applying slot k:
  // one-hot for every slot but the last, all ones for the last slot, which
  // also tells the selector to evaluate. Callers truncate to their width.
  function automatic logic [31:0] wr_code(input int k, input int nsat);
    if (k < nsat - 1) begin
      return 32'd1 << k;
    end
    return '1;
  endfunction

endpackage

// File: rtl/flip_candidate_sequencer.sv
// -----------------------------------------------------------------------------
// flip_candidate_sequencer
// Control stage in front of the variable flip selector. Takes the literal IDs
// of one unsatisfied clause, fetches each variable's clause-broken and mask
// vectors from the clause-state lookup (one req/ack per literal), feeds them to
// the selector with the matching write-enable code, then hands the selector's
// winner to the flip stage over a valid/ready handshake.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, clause_vars_i  clause request (accepted while clause_ready_o=1)
//   clause_ready_o          high while idle
//   lut_req_o, lut_addr_o   lookup request and variable ID
//   lut_ack_i, lut_broken_i, lut_mask_i   lookup response
//   clause_broken_o, mask_bits_o, wr_en_o, break_values_valid_o  to selector
//   selected_i, clause_valid_bits_i       from selector
//   flip_valid_o, flip_ready_i, flip_var_o, flip_clause_bits_o   to flip stage
//   err_o                   one-cycle pulse: empty clause or bad selection
// -----------------------------------------------------------------------------
module flip_candidate_sequencer
  import flip_candidate_sequencer_pkg::*;
#(
  parameter int  MAX_CLAUSES_PER_VARIABLE = MC,
  parameter int  NSAT                     = DEFAULT_NSAT,
  parameter int  VAR_BITS                 = DEFAULT_VAR_BITS,
  localparam int SEL_BITS                 = $clog2(NSAT)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [NSAT*VAR_BITS-1:0]            clause_vars_i,
  output logic                                clause_ready_o,
  output logic                                lut_req_o,
  output logic [VAR_BITS-1:0]                 lut_addr_o,
  input  logic                                lut_ack_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] lut_broken_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] lut_mask_i,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_o,
  output logic [SEL_BITS-1:0]                 wr_en_o,
  output logic [NSAT-1:0]                     break_values_valid_o,
  input  logic [SEL_BITS-1:0]                 selected_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_valid_bits_i,
  output logic                                flip_valid_o,
  input  logic                                flip_ready_i,
  output logic [VAR_BITS-1:0]                 flip_var_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] flip_clause_bits_o,
  output logic                                err_o
);

  localparam int MCW = MAX_CLAUSES_PER_VARIABLE;

  seq_state_e           state_q, state_d;
  logic [VAR_BITS-1:0]  vars_q [NSAT];
  logic [SEL_BITS-1:0]  k_q;
  logic [MCW-1:0]       hold_broken_q, hold_mask_q;
  logic [VAR_BITS-1:0]  flip_var_q;
  logic [MCW-1:0]       flip_bits_q;
  logic                 err_q, err_d;

  logic [VAR_BITS-1:0]  cur_var;
  logic [VAR_BITS-1:0]  sel_var;
  logic                 last_slot;

  assign cur_var   = vars_q[k_q];
  assign last_slot = (k_q == SEL_BITS'(NSAT - 1));

  // Slot mux for the selector's choice. A code >= NSAT matches no slot and
  // falls through as ID 0, which the SETTLE check already treats as an error.
  always_comb begin
    sel_var = '0;
    for (int i = 0; i < NSAT; i++) begin
      if (selected_i == SEL_BITS'(i)) begin
        sel_var = vars_q[i];
      end
    end
  end

  always_comb begin
    break_values_valid_o = '0;
    for (int i = 0; i < NSAT; i++) begin
      break_values_valid_o[i] = (vars_q[i] != '0);
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs.
  // NOTE: every signal written here gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    err_d           = 1'b0;
    clause_ready_o  = 1'b0;
    lut_req_o       = 1'b0;
    lut_addr_o      = '0;
    wr_en_o         = '0;
    clause_broken_o = '0;
    mask_bits_o     = '0;
    flip_valid_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        clause_ready_o = 1'b1;
        if (start_i) begin
          if (clause_vars_i == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        // Empty slots skip the lookup entirely; the hold registers get zeros.
        if (cur_var != '0) begin
          lut_req_o  = 1'b1;
          lut_addr_o = cur_var;
          if (lut_ack_i) begin
            state_d = APPLY;
          end
        end else begin
          state_d = APPLY;
        end
      end

      APPLY: begin
        clause_broken_o = hold_broken_q;
        mask_bits_o     = hold_mask_q;
        wr_en_o         = SEL_BITS'(wr_code(int'(k_q), NSAT));
        state_d         = last_slot ? SETTLE : FETCH;
      end

      SETTLE: begin
        if (sel_var == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end

      OUT: begin
        flip_valid_o = 1'b1;
        if (flip_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: latched clause, slot index, hold and result registers.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the clause array is reset too: a reset must discard the latched
      // clause, and break_values_valid_o is derived straight from it.
      for (int i = 0; i < NSAT; i++) begin
        vars_q[i] <= '0;
      end
      k_q           <= '0;
      hold_broken_q <= '0;
      hold_mask_q   <= '0;
      flip_var_q    <= '0;
      flip_bits_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      err_q <= err_d;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            for (int i = 0; i < NSAT; i++) begin
              vars_q[i] <= clause_vars_i[i*VAR_BITS +: VAR_BITS];
            end
            k_q <= '0;
          end
        end
        FETCH: begin
          if (cur_var == '0) begin
            hold_broken_q <= '0;
            hold_mask_q   <= '0;
          end else if (lut_ack_i) begin
            hold_broken_q <= lut_broken_i;
            hold_mask_q   <= lut_mask_i;
          end
        end
        APPLY: begin
          if (!last_slot) begin
            k_q <= k_q + SEL_BITS'(1);
          end
        end
        SETTLE: begin
          flip_var_q  <= sel_var;
          flip_bits_q <= clause_valid_bits_i;
        end
        default: ;
      endcase
    end
  end

  assign flip_var_o         = flip_var_q;
  assign flip_clause_bits_o = flip_bits_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_flip_candidate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flip_candidate_sequencer
// Self-checking bench. Each clause is described by its literal IDs, per-literal
// lookup wait states, the stubbed selector choice and the flip-stage ready
// delay; the expected timeline (apply cycles, result cycle, error cycle) is
// computed up front from the cycle-count rules, then observed cycle by cycle.
// Cycle numbering: the edge that samples start_i is cycle 0.
// -----------------------------------------------------------------------------
module tb_flip_candidate_sequencer;

  localparam int MC   = 20;
  localparam int NSAT = 3;
  localparam int VB   = 16;
  localparam int SB   = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [NSAT*VB-1:0] clause_vars_i = '0;
  logic              clause_ready_o;
  logic              lut_req_o;
  logic [VB-1:0]     lut_addr_o;
  logic              lut_ack_i = 1'b0;
  logic [MC-1:0]     lut_broken_i = '0;
  logic [MC-1:0]     lut_mask_i = '0;
  logic [MC-1:0]     clause_broken_o;
  logic [MC-1:0]     mask_bits_o;
  logic [SB-1:0]     wr_en_o;
  logic [NSAT-1:0]   break_values_valid_o;
  logic [SB-1:0]     selected_i = '0;
  logic [MC-1:0]     clause_valid_bits_i = '0;
  logic              flip_valid_o;
  logic              flip_ready_i = 1'b0;
  logic [VB-1:0]     flip_var_o;
  logic [MC-1:0]     flip_clause_bits_o;
  logic              err_o;

  int n_tests = 0;
  int n_fail  = 0;

  flip_candidate_sequencer dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .start_i              (start_i),
    .clause_vars_i        (clause_vars_i),
    .clause_ready_o       (clause_ready_o),
    .lut_req_o            (lut_req_o),
    .lut_addr_o           (lut_addr_o),
    .lut_ack_i            (lut_ack_i),
    .lut_broken_i         (lut_broken_i),
    .lut_mask_i           (lut_mask_i),
    .clause_broken_o      (clause_broken_o),
    .mask_bits_o          (mask_bits_o),
    .wr_en_o              (wr_en_o),
    .break_values_valid_o (break_values_valid_o),
    .selected_i           (selected_i),
    .clause_valid_bits_i  (clause_valid_bits_i),
    .flip_valid_o         (flip_valid_o),
    .flip_ready_i         (flip_ready_i),
    .flip_var_o           (flip_var_o),
    .flip_clause_bits_o   (flip_clause_bits_o),
    .err_o                (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Lookup table contents: distinct, nonzero vectors per variable ID.
  function automatic logic [MC-1:0] brk(input logic [VB-1:0] x);
    return MC'({x, 4'h0} ^ {4'h0, ~x});
  endfunction

  function automatic logic [MC-1:0] msk(input logic [VB-1:0] x);
    return {x[7:0], x[15:4]} ^ 20'h5A5A5;
  endfunction

  task automatic drive_idle_ack();
    // Random acks/data while nothing is requested: the DUT must ignore them.
    lut_ack_i    = 1'($urandom_range(0, 1));
    lut_broken_i = MC'($urandom);
    lut_mask_i   = MC'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic run_clause(input logic [VB-1:0] a0, a1, a2,
                            input int d0, d1, d2, input int sel, input int rdy_wait);
    logic [VB-1:0] v[3];
    int            d[3];
    int            apply_cyc[3];
    logic [MC-1:0] eb[3], em[3];
    logic [SB-1:0] ecode[3];
    int            nz_q[$];
    int            t, out_cyc, err_cyc, end_cyc, w, acked, apply_idx;
    logic [VB-1:0] exp_flip;
    logic [MC-1:0] bits;
    logic [2:0]    exp_bvv;
    logic          all_zero;

    v     = '{a0, a1, a2};
    d     = '{d0, d1, d2};
    ecode = '{2'b01, 2'b10, 2'b11};
    bits  = MC'($urandom);
    all_zero = (a0 == '0) && (a1 == '0) && (a2 == '0);

    // Reference timeline: each slot costs one FETCH cycle (+ wait states for a
    // real lookup) plus one APPLY cycle; then SETTLE, then the result.
    t = 1;
    for (int k = 0; k < NSAT; k++) begin
      exp_bvv[k] = (v[k] != '0);
      if (v[k] != '0) begin
        nz_q.push_back(k);
        t += d[k];
        eb[k] = brk(v[k]);
        em[k] = msk(v[k]);
      end else begin
        eb[k] = '0;
        em[k] = '0;
      end
      apply_cyc[k] = t + 1;
      t += 2;
    end
    exp_flip = '0;
    if (sel < NSAT) exp_flip = v[sel];
    out_cyc = -1;
    err_cyc = -1;
    if (all_zero) begin
      err_cyc = 1;
      end_cyc = 1;
    end else if (exp_flip == '0) begin
      err_cyc = t + 1;
      end_cyc = t + 1;
    end else begin
      out_cyc = t + 1;
      end_cyc = t + 1;
    end

    selected_i          = SB'(sel);
    clause_valid_bits_i = bits;
    flip_ready_i        = 1'b0;
    check("idle_ready", clause_ready_o, 1);
    start_i       = 1'b1;
    clause_vars_i = {a2, a1, a0};
    w = 0; acked = 0; apply_idx = 0;

    for (int c = 1; c <= end_cyc; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      check("err", err_o, (c == err_cyc));
      check("bvv", break_values_valid_o, exp_bvv);
      if (all_zero) check("zero_ready", clause_ready_o, 1);
      if (apply_idx < NSAT && c == apply_cyc[apply_idx]) begin
        check("wr_en", wr_en_o, ecode[apply_idx]);
        check("broken", clause_broken_o, eb[apply_idx]);
        check("mask", mask_bits_o, em[apply_idx]);
        apply_idx++;
      end else begin
        check("wr_idle", wr_en_o, 0);
        check("data_idle", {clause_broken_o, mask_bits_o}, 0);
      end
      check("valid", flip_valid_o, (c == out_cyc));
      if (c == out_cyc) begin
        check("flip_var", flip_var_o, exp_flip);
        check("flip_bits", flip_clause_bits_o, bits);
      end
      // Lookup responder: ack after d[slot] wait cycles of the request.
      if (lut_req_o) begin
        if (acked >= nz_q.size()) begin
          check("spurious_req", lut_req_o, 0);
          lut_ack_i = 1'b0;
        end else begin
          check("lut_addr", lut_addr_o, v[nz_q[acked]]);
          if (w == d[nz_q[acked]]) begin
            lut_ack_i    = 1'b1;
            lut_broken_i = brk(lut_addr_o);
            lut_mask_i   = msk(lut_addr_o);
            w = 0;
            acked++;
          end else begin
            lut_ack_i = 1'b0;
            w++;
          end
        end
      end else begin
        drive_idle_ack();
      end
    end
    lut_ack_i = 1'b0;
    check("req_count", acked, nz_q.size());

    if (out_cyc > 0) begin
      // Hold ready low; a start pulse in this window must be ignored.
      for (int i = 0; i < rdy_wait; i++) begin
        start_i       = (i == 1);
        clause_vars_i = {16'd1, 16'd2, 16'd3};
        @(negedge clk_i);
        start_i = 1'b0;
        check("hold_valid", flip_valid_o, 1);
        check("hold_var", flip_var_o, exp_flip);
        check("hold_bits", flip_clause_bits_o, bits);
      end
      flip_ready_i = 1'b1;
      @(negedge clk_i);
      flip_ready_i = 1'b0;
      check("post_valid", flip_valid_o, 0);
      check("post_ready", clause_ready_o, 1);
      @(negedge clk_i);
      check("post_no_req", lut_req_o, 0);
    end else begin
      @(negedge clk_i);
      check("err_pulse_end", err_o, 0);
      check("err_ready", clause_ready_o, 1);
      check("err_no_req", lut_req_o, 0);
    end
  endtask

  initial begin
    logic [VB-1:0] rv[3];

    // Reset state.
    repeat (2) @(negedge clk_i);
    check("rst_ready", clause_ready_o, 1);
    check("rst_req", lut_req_o, 0);
    check("rst_wr", wr_en_o, 0);
    check("rst_valid", flip_valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_var", flip_var_o, 0);
    check("rst_bvv", break_values_valid_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed cases.
    run_clause(16'd5, 16'd9, 16'd12, 0, 0, 0, 1, 0);   // flip 9 at cycle 8
    run_clause(16'd5, 16'd9, 16'd12, 0, 3, 0, 1, 0);   // flip at cycle 11
    run_clause(16'd7, 16'd0, 16'd3,  0, 0, 0, 2, 0);   // empty middle slot
    run_clause(16'd0, 16'd0, 16'd0,  0, 0, 0, 0, 0);   // empty clause error
    run_clause(16'd5, 16'd9, 16'd12, 1, 0, 2, 0, 4);   // ready held low 4 cycles
    run_clause(16'd5, 16'd9, 16'd12, 0, 0, 0, 3, 0);   // selector code out of range
    run_clause(16'd7, 16'd0, 16'd3,  0, 0, 1, 1, 0);   // selector picks empty slot

    // Reset during FETCH(1) with the request pending.
    selected_i    = 2'd1;
    start_i       = 1'b1;
    clause_vars_i = {16'd12, 16'd9, 16'd5};
    @(negedge clk_i);
    start_i      = 1'b0;
    lut_ack_i    = 1'b1;
    lut_broken_i = brk(16'd5);
    lut_mask_i   = msk(16'd5);
    @(negedge clk_i);
    lut_ack_i = 1'b0;
    @(negedge clk_i);
    check("mid_req", lut_req_o, 1);
    check("mid_addr", lut_addr_o, 16'd9);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mrst_req", lut_req_o, 0);
    check("mrst_wr", wr_en_o, 0);
    check("mrst_ready", clause_ready_o, 1);
    check("mrst_bvv", break_values_valid_o, 0);
    run_clause(16'd5, 16'd9, 16'd12, 0, 0, 0, 1, 1);

    // Randomized clauses.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NSAT; k++) begin
        rv[k] = ($urandom_range(0, 3) == 0) ? '0 : VB'($urandom_range(1, 65535));
      end
      run_clause(rv[0], rv[1], rv[2],
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
